// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Used by the RX block, the TX block and the baud tick generator.
package uart_pkg;

  localparam int UART_OVER      = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line, plus a registered
// falling-edge pulse taken from the synchronised sample and its predecessor.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_fall;

  // Flops reset to the idle (high) level so reset never fakes a start edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fall <= r_prev & ~r_sync;
    end
  end

  assign o_rx_sync = r_sync;
  assign o_fall    = r_fall;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with valid/ready output and framing/overrun errors.
// Define UART_RX_PARITY_EN to add a parity bit (rule chosen by PARITY_ODD).
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVER       = UART_OVER,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_oversample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVER);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TMID  = TW'(OVER / 2 - 1);
  localparam logic [TW-1:0] TLAST = TW'(OVER - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_next;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_edgePend;
  logic                 w_rxSync;
  logic                 w_fall;
  logic                 w_midStart;
  logic                 w_bitEnd;
  logic                 w_shiftEn;
  logic                 w_complete;
  logic                 w_parErr;

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx      (i_rx),
    .o_rx_sync (w_rxSync),
    .o_fall    (w_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= RX_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (i_oversample_tick && (r_edgePend || w_fall)) w_next = RX_START;
      RX_START: if (w_midStart) w_next = w_rxSync ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
      RX_DATA:   if (w_bitEnd && r_bcnt == BLAST) w_next = RX_PARITY;
      RX_PARITY: if (w_bitEnd) w_next = RX_STOP;
`else
      RX_DATA:   if (w_bitEnd && r_bcnt == BLAST) w_next = RX_STOP;
`endif
      RX_STOP:  if (w_bitEnd) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != RX_IDLE);
    w_midStart = i_oversample_tick && (r_state == RX_START) && (r_tcnt == TMID);
    w_bitEnd   = i_oversample_tick && (r_tcnt == TLAST);
    w_shiftEn  = w_bitEnd && (r_state == RX_DATA);
    w_complete = w_bitEnd && (r_state == RX_STOP);
  end

  // A falling edge only counts while idle; edges seen mid-frame are discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != RX_IDLE || i_oversample_tick) r_edgePend <= 1'b0;
    else if (w_fall)                                        r_edgePend <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else if (i_oversample_tick) begin
      if (r_state == RX_IDLE || w_midStart || r_tcnt == TLAST) r_tcnt <= '0;
      else                                                     r_tcnt <= r_tcnt + 1'b1;
      if (r_state != RX_DATA) r_bcnt <= '0;
      else if (w_bitEnd)      r_bcnt <= (r_bcnt == BLAST) ? '0 : r_bcnt + 1'b1;
      if (w_shiftEn) r_shift <= {w_rxSync, r_shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parErr;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_parErr <= 1'b0;
    else if (r_state == RX_PARITY && w_bitEnd)
      r_parErr <= (^r_shift) ^ w_rxSync ^ (PARITY_ODD != 0);
  end

  assign w_parErr = r_parErr;
`else
  assign w_parErr = 1'b0;
`endif

  // An unaccepted byte is never overwritten; the new frame is dropped instead.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (w_complete) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data    <= r_shift;
          o_rx_valid   <= 1'b1;
          o_frame_err  <= ~w_rxSync;
          o_parity_err <= w_parErr;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid   <= 1'b0;
        o_frame_err  <= 1'b0;
        o_parity_err <= 1'b0;
      end
    end
  end

endmodule
